fpadd_arbiter: RTL

FPADD_ARBITER -- requirements
Module: fpadd_arbiter

---
 rtl/fpadd_arb_pkg.sv | 11 +
 rtl/FPAdder.sv | 80 ++++++++
 rtl/fpadd_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/fpadd_arb_pkg.sv
// Shared types and widths for the two-requester FP adder arbiter.
package fpadd_arb_pkg;
  localparam int FP_W  = 64;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;
endpackage

// File: rtl/FPAdder.sv
// Combinational IEEE-754 double adder, round-to-nearest-even, with subnormal,
// infinity and NaN handling.
module FPAdder (
  input  logic [63:0] A,
  input  logic [63:0] B,
  output logic [63:0] out
);
  logic [63:0] x, y;
  logic [10:0] ex, ey, dexp;
  logic [55:0] big, small_full, small_al, lost_mask, norm;
  logic [56:0] sum;
  logic [5:0]  lz, sh;
  logic [11:0] e, e_m1;
  logic [53:0] mant_r;
  logic        sign, round_up, x_nan, x_inf, y_inf;

  // NOTE: every variable below is assigned on every path before use, so no
  // latch can be inferred even though several are conditionally overwritten.
  always_comb begin
    // Order by magnitude so the effective subtraction never goes negative.
    if (A[62:0] >= B[62:0]) begin
      x = A;
      y = B;
    end else begin
      x = B;
      y = A;
    end
    ex         = (x[62:52] == 11'd0) ? 11'd1 : x[62:52];
    ey         = (y[62:52] == 11'd0) ? 11'd1 : y[62:52];
    dexp       = ex - ey;
    big        = {|x[62:52], x[51:0], 3'b000};
    small_full = {|y[62:52], y[51:0], 3'b000};
    lost_mask  = '0;
    if (dexp > 11'd55) begin
      small_al = {55'd0, |y[62:0]};
    end else begin
      lost_mask   = (56'd1 << dexp) - 56'd1;
      small_al    = small_full >> dexp;
      small_al[0] = small_al[0] | (|(small_full & lost_mask));
    end

    if (x[63] == y[63]) sum = {1'b0, big} + {1'b0, small_al};
    else                sum = {1'b0, big} - {1'b0, small_al};

    lz = 6'd56;
    for (int i = 0; i < 56; i++) begin
      if (sum[i]) lz = 6'(55 - i);
    end

    e    = {1'b0, ex};
    e_m1 = e - 12'd1;
    sh   = '0;
    if (sum[56]) begin
      norm = {sum[56:2], sum[1] | sum[0]};
      e    = e + 12'd1;
    end else begin
      // Stop normalising at the minimum exponent; what remains is subnormal.
      sh   = ({6'd0, lz} > e_m1) ? e_m1[5:0] : lz;
      norm = sum[55:0] << sh;
      e    = e - {6'd0, sh};
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r   = {1'b0, norm[55:3]} + {53'd0, round_up};
    if (mant_r[53]) begin
      mant_r = mant_r >> 1;
      e      = e + 12'd1;
    end

    sign = (sum == '0) ? (x[63] & y[63]) : x[63];
    out  = {sign, (mant_r[52] ? e[10:0] : 11'd0), mant_r[51:0]};
    if (e >= 12'd2047) out = {sign, 11'h7FF, 52'd0};

    x_nan = (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
    x_inf = (x[62:52] == 11'h7FF) && (x[51:0] == 52'd0);
    y_inf = (y[62:52] == 11'h7FF) && (y[51:0] == 52'd0);
    if (x_nan)      out = {x[63], 11'h7FF, 1'b1, x[50:0]};
    else if (x_inf) out = (y_inf && (x[63] != y[63])) ? 64'h7FF8_0000_0000_0000 : x;
  end
endmodule

// File: rtl/fpadd_arbiter.sv
// Round-robin arbiter granting two requesters access to one shared FP adder;
// one operation in flight, result held until the consumer takes it.
module fpadd_arbiter
  import fpadd_arb_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [FP_W-1:0] req0_a,
  input  logic [FP_W-1:0] req0_b,
  input  logic            req0_sub,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [FP_W-1:0] req1_a,
  input  logic [FP_W-1:0] req1_b,
  input  logic            req1_sub,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [FP_W-1:0] rsp_data,
  output logic            busy
);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

  state_t          state, state_nxt;
  logic            last_grant, sel, take;
  logic [CNT_W-1:0] cnt;
  logic [FP_W-1:0] op_a, op_b, add_b, add_out;
  logic            op_sub, op_id;

  // On a tie the requester not served last wins.
  always_comb begin
    if (req0_valid && req1_valid) sel = ~last_grant;
    else                          sel = req1_valid;
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    take       = 1'b0;
    unique case (state)
      IDLE: begin
        req0_ready = ~sel;
        req1_ready = sel;
        take       = sel ? req1_valid : req0_valid;
        if (take) state_nxt = EXEC;
      end
      EXEC:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      op_sub     <= 1'b0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
    end else begin
      unique case (state)
        IDLE: if (take) begin
          op_a       <= sel ? req1_a : req0_a;
          op_b       <= sel ? req1_b : req0_b;
          op_sub     <= sel ? req1_sub : req0_sub;
          op_id      <= sel;
          last_grant <= sel;
          cnt        <= CNT_LOAD;
        end
        EXEC: if (cnt == '0) begin
          rsp_data  <= add_out;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Subtraction is addition with the second operand's sign flipped.
  assign add_b = {op_b[FP_W-1] ^ op_sub, op_b[FP_W-2:0]};

  FPAdder u_add (
    .A  (op_a),
    .B  (add_b),
    .out(add_out)
  );
endmodule
